// File: rtl/scan_sequencer_if.sv
// rtl/scan_sequencer_if.sv - control and decoder-drive bundle for the scan sequencer
interface scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               i_start;
    logic               i_stop;
    logic               i_mode;
    logic [3:0]         i_mask;
    logic [DWELL_W-1:0] i_dwell;
    logic               o_en;
    logic [1:0]         o_a;
    logic               o_busy;
    logic               o_ch_tick;
    logic               o_done;

    modport master (
        output i_start, i_stop, i_mode, i_mask, i_dwell,
        input  o_en, o_a, o_busy, o_ch_tick, o_done
    );

    modport slave (
        input  i_start, i_stop, i_mode, i_mask, i_dwell,
        output o_en, o_a, o_busy, o_ch_tick, o_done
    );
endinterface

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - walks the set bits of a 4-bit channel mask, holding each for a dwell time
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    scan_sequencer_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state;
    logic [3:0]         mask_q;
    logic               mode_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;
    logic               en_q;
    logic [1:0]         a_q;
    logic               busy_q;
    logic               tick_q;
    logic               done_q;

    logic               start_ok;
    logic [2:0]         next_hit;
    logic [1:0]         first_new;
    logic [1:0]         first_latched;

    // Counter holds the cycles remaining after the current one; dwell 0 behaves as 1.
    function automatic logic [DWELL_W-1:0] reload(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Returns {found, index} of the nearest set bit strictly above cur.
    function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    always_comb begin
        start_ok      = bus.i_start && !bus.i_stop && (bus.i_mask != 4'b0000);
        next_hit      = next_above(mask_q, a_q);
        first_new     = lowest_bit(bus.i_mask);
        first_latched = lowest_bit(mask_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            mask_q  <= 4'b0000;
            mode_q  <= 1'b0;
            dwell_q <= '0;
            cnt     <= '0;
            en_q    <= 1'b0;
            a_q     <= 2'd0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state   <= SCAN;
                        mask_q  <= bus.i_mask;
                        mode_q  <= bus.i_mode;
                        dwell_q <= bus.i_dwell;
                        cnt     <= reload(bus.i_dwell);
                        a_q     <= first_new;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        tick_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (bus.i_stop) begin
                        state  <= IDLE;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (next_hit[2]) begin
                        a_q    <= next_hit[1:0];
                        cnt    <= reload(dwell_q);
                        tick_q <= 1'b1;
                    end else if (mode_q) begin
                        a_q    <= first_latched;
                        cnt    <= reload(dwell_q);
                        tick_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_en      = en_q;
    assign bus.o_a       = a_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_ch_tick = tick_q;
    assign bus.o_done    = done_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - directed self-checking bench for scan_sequencer
module tb_scan_sequencer;
    logic i_clk;
    logic i_rst_n;
    int   total;
    int   bad;

    scan_sequencer_if #(.DWELL_W(8)) bus ();

    scan_sequencer #(.DWELL_W(8)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic en, input logic [1:0] a,
                             input logic busy, input logic tick, input logic done);
        check({tag, ".en"},   bus.o_en,      en);
        check({tag, ".a"},    bus.o_a,       a);
        check({tag, ".busy"}, bus.o_busy,    busy);
        check({tag, ".tick"}, bus.o_ch_tick, tick);
        check({tag, ".done"}, bus.o_done,    done);
    endtask

    task automatic start_scan(input logic [3:0] m, input logic [7:0] d, input logic md);
        bus.i_mask  = m;
        bus.i_dwell = d;
        bus.i_mode  = md;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_rst_n     = 1'b0;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        bus.i_mode  = 1'b0;
        bus.i_mask  = 4'b0000;
        bus.i_dwell = 8'd0;
        #1;
        check_all("reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        i_rst_n = 1'b1;
        step();
        check_all("post_reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // one-shot, full mask, dwell 2
        start_scan(4'b1111, 8'd2, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            check_all($sformatf("oneshot_c%0d", k), 1'b1, 2'((k - 1) / 2), 1'b1,
                      (k % 2) == 1, 1'b0);
            if (k < 8) step();
        end
        step();
        check_all("oneshot_done", 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        check_all("oneshot_after", 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);

        // continuous, mask 1010, dwell 3, then stop mid-dwell
        start_scan(4'b1010, 8'd3, 1'b1);
        for (int k = 1; k <= 13; k++) begin
            check_all($sformatf("cont_c%0d", k), 1'b1, (((k - 1) / 3) % 2) ? 2'd3 : 2'd1,
                      1'b1, ((k - 1) % 3) == 0, 1'b0);
            if (k < 13) step();
        end
        bus.i_stop = 1'b1;
        step();
        bus.i_stop = 1'b0;
        check_all("cont_stop", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        check_all("cont_stop2", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);

        // single channel, dwell 0, continuous
        start_scan(4'b0100, 8'd0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            check_all($sformatf("single_c%0d", k), 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
            step();
        end
        bus.i_stop = 1'b1;
        step();
        bus.i_stop = 1'b0;
        check_all("single_stop", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);

        // ignored starts: empty mask, and start together with stop
        start_scan(4'b0000, 8'd1, 1'b0);
        check_all("zero_mask", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        check_all("zero_mask2", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        bus.i_stop = 1'b1;
        start_scan(4'b1111, 8'd1, 1'b0);
        bus.i_stop = 1'b0;
        check_all("start_stop", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        check_all("start_stop2", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);

        // stop coincident with pass completion suppresses done
        start_scan(4'b1000, 8'd1, 1'b0);
        check_all("last_ch", 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        bus.i_stop = 1'b1;
        step();
        bus.i_stop = 1'b0;
        check_all("stop_at_end", 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-scan
        start_scan(4'b1111, 8'd5, 1'b1);
        step();
        step();
        check_all("pre_rst", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        i_rst_n = 1'b1;
        step();
        check_all("rst_release", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        start_scan(4'b0001, 8'd1, 1'b0);
        check_all("post_rst_c1", 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
        step();
        check_all("post_rst_done", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();

        // input changes and restart during continuous scan have no effect
        start_scan(4'b0011, 8'd1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin
                bus.i_mask  = 4'b1100;
                bus.i_dwell = 8'd7;
                bus.i_mode  = 1'b0;
                bus.i_start = 1'b1;
            end
            if (k == 3) bus.i_start = 1'b0;
            check_all($sformatf("frozen_c%0d", k), 1'b1, 2'((k - 1) % 2), 1'b1, 1'b1, 1'b0);
            step();
        end
        bus.i_stop = 1'b1;
        step();
        bus.i_stop = 1'b0;
        check_all("frozen_stop", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
